// File: rtl/process_data_udiv_43ns_21ns_23_seq.sv
// Sequential unsigned radix-2 restoring divider with valid/ready handshakes on both sides.
// Divide-by-zero and quotient overflow finish in one cycle with a saturated quotient.
// A normal divide runs QUOTIENT_WIDTH iterations, one per clock.
// Optional build macro PROCESS_DATA_UDIV_REM_EN adds a remainder output port.
module process_data_udiv_43ns_21ns_23_seq #(
  parameter int unsigned DIVIDEND_WIDTH = 43,
  parameter int unsigned DIVISOR_WIDTH  = 21,
  parameter int unsigned QUOTIENT_WIDTH = 23
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic                      ovf,
`ifdef PROCESS_DATA_UDIV_REM_EN
  output logic [DIVISOR_WIDTH-1:0]  remainder,
`endif
  output logic                      dbz
);

  localparam int unsigned HiW  = DIVIDEND_WIDTH - QUOTIENT_WIDTH;
  localparam int unsigned RemW = DIVISOR_WIDTH + 1;
  localparam int unsigned CntW = (QUOTIENT_WIDTH > 1) ? $clog2(QUOTIENT_WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(QUOTIENT_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                    state_q, state_d;
  // Partial remainder; always below the divisor, so DIVISOR_WIDTH bits suffice.
  logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
  // Low dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [QUOTIENT_WIDTH-1:0] qd_q, qd_d;
  logic [DIVISOR_WIDTH-1:0]  dsr_q, dsr_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      dbz_q, dbz_d;

  logic [HiW-1:0]            dvd_hi;
  logic [RemW-1:0]           shifted;
  logic [RemW-1:0]           dsr_ext;
  logic                      ge;

  // Datapath for one restoring iteration: shift in next dividend bit, trial-compare.
  always_comb begin
    dvd_hi  = dividend[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH];
    shifted = {rem_q, qd_q[QUOTIENT_WIDTH-1]};
    dsr_ext = {1'b0, dsr_q};
    ge      = (shifted >= dsr_ext);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    qd_d      = qd_q;
    dsr_d     = dsr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          dsr_d = divisor;
          if (divisor == '0) begin
            qd_d    = '1;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
`ifdef PROCESS_DATA_UDIV_REM_EN
            rem_d   = dividend[DIVISOR_WIDTH-1:0];
`else
            rem_d   = '0;
`endif
            state_d = StDone;
          end else if (DIVISOR_WIDTH'(dvd_hi) >= divisor) begin
            // Quotient would not fit: saturate.
            qd_d    = '1;
            ovf_d   = 1'b1;
            dbz_d   = 1'b0;
            rem_d   = '0;
            state_d = StDone;
          end else begin
            rem_d   = DIVISOR_WIDTH'(dvd_hi);
            qd_d    = dividend[QUOTIENT_WIDTH-1:0];
            cnt_d   = CntMax;
            ovf_d   = 1'b0;
            dbz_d   = 1'b0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = ge ? DIVISOR_WIDTH'(shifted - dsr_ext) : DIVISOR_WIDTH'(shifted);
        qd_d  = {qd_q[QUOTIENT_WIDTH-2:0], ge};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = StDone;
`ifndef PROCESS_DATA_UDIV_REM_EN
          rem_d   = '0;
`endif
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      qd_q    <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      qd_q    <= qd_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient = qd_q;
  assign ovf      = ovf_q;
  assign dbz      = dbz_q;
`ifdef PROCESS_DATA_UDIV_REM_EN
  assign remainder = rem_q;
`endif

endmodule

// File: tb/tb_process_data_udiv_43ns_21ns_23_seq.sv
// Self-checking bench for the sequential unsigned divider; reference model uses plain / and %.
module tb_process_data_udiv_43ns_21ns_23_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        in_valid;
  logic        in_ready;
  logic [42:0] dividend;
  logic [20:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] quotient;
  logic        ovf;
  logic        dbz;
  logic [20:0] remainder;

  int vecs = 0;
  int errs = 0;

  always #5 ap_clk = ~ap_clk;

  process_data_udiv_43ns_21ns_23_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .ovf       (ovf),
`ifdef PROCESS_DATA_UDIV_REM_EN
    .remainder (remainder),
`endif
    .dbz       (dbz)
  );

`ifndef PROCESS_DATA_UDIV_REM_EN
  assign remainder = '0;
`endif

  // Reference: mathematical division with saturation rules.
  function automatic void model(input logic [42:0] a, input logic [20:0] b,
                                output logic [22:0] q, output logic o, output logic z,
                                output logic [20:0] r, output int lat);
    longint unsigned aa, bb, qq;
    aa = 64'(a);
    bb = 64'(b);
    if (bb == 0) begin
      q = '1; o = 1'b0; z = 1'b1; r = a[20:0]; lat = 1;
    end else begin
      qq = aa / bb;
      if (qq > 64'h7FFFFF) begin
        q = '1; o = 1'b1; z = 1'b0; r = '0; lat = 1;
      end else begin
        q = qq[22:0]; o = 1'b0; z = 1'b0; r = 21'(aa % bb); lat = 24;
      end
    end
  endfunction

  // Drives one operation, waits for the result, captures it, and completes the handshake.
  task automatic run_op(input logic [42:0] a, input logic [20:0] b,
                        output logic [22:0] q, output logic o, output logic z,
                        output logic [20:0] r, output int lat, output bit timeout);
    int n;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    timeout = !out_valid;
    lat = n;
    q = quotient; o = ovf; z = dbz; r = remainder;
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [42:0] a, input logic [20:0] b);
    logic [22:0] q, eq;
    logic o, z, eo, ez;
    logic [20:0] r, er;
    int lat, elat;
    bit to;
    model(a, b, eq, eo, ez, er, elat);
    run_op(a, b, q, o, z, r, lat, to);
    vecs++;
    if (to) begin
      errs++;
      $display("FAIL %s timeout: out_valid never rose, required within 100 cycles", name);
    end else begin
      if ({q, o, z} !== {eq, eo, ez}) begin
        errs++;
        $display("FAIL %s result a=%0d b=%0d: got q=%h ovf=%b dbz=%b, required q=%h ovf=%b dbz=%b",
                 name, a, b, q, o, z, eq, eo, ez);
      end
      vecs++;
      if (lat !== elat) begin
        errs++;
        $display("FAIL %s latency a=%0d b=%0d: got %0d, required %0d", name, a, b, lat, elat);
      end
`ifdef PROCESS_DATA_UDIV_REM_EN
      vecs++;
      if (r !== er) begin
        errs++;
        $display("FAIL %s remainder a=%0d b=%0d: got %0d, required %0d", name, a, b, r, er);
      end
`endif
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    vecs++;
    if ({in_ready, out_valid, quotient, ovf, dbz, remainder} !== {1'b1, 1'b0, 23'd0, 1'b0, 1'b0, 21'd0}) begin
      errs++;
      $display("FAIL reset_state: got rdy=%b vld=%b q=%h ovf=%b dbz=%b rem=%h, required 1 0 0 0 0 0",
               in_ready, out_valid, quotient, ovf, dbz, remainder);
    end
  endtask

  task automatic test_directed();
    check_op("dir_1000_7", 43'd1000, 21'd7);
    check_op("dir_max_fit", 43'd41943039, 21'd5);
    check_op("dir_ovf_pow42", 43'h400_0000_0000, 21'd1);
    check_op("dir_ovf_edge", 43'd41943040, 21'd5);
    check_op("dir_dbz", 43'd12345, 21'd0);
  endtask

  task automatic test_random();
    logic [42:0] a;
    logic [20:0] b;
    longint unsigned lim;
    for (int i = 0; i < 40; i++) begin
      int mode;
      mode = $urandom_range(0, 9);
      b = 21'($urandom_range(1, 21'h1FFFFF));
      a = 43'({$urandom(), $urandom()});
      if (mode == 0) begin
        b = '0;
      end else if (mode >= 3) begin
        lim = 64'(b) << 23;
        a = 43'({$urandom(), $urandom()} % lim);
      end
      check_op("random", a, b);
    end
  endtask

  task automatic test_backpressure();
    logic [22:0] q0;
    int n;
    dividend = 43'd1000;
    divisor  = 21'd7;
    in_valid = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    vecs++;
    if (!out_valid) begin
      errs++;
      $display("FAIL bp_wait timeout: out_valid=%b, required 1", out_valid);
    end
    q0 = quotient;
    vecs++;
    if (q0 !== 23'd142) begin
      errs++;
      $display("FAIL bp_quotient: got %0d, required 142", q0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      vecs++;
      if ({out_valid, in_ready, quotient, ovf, dbz} !== {1'b1, 1'b0, 23'd142, 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b q=%0d ovf=%b dbz=%b, required 1 0 142 0 0",
                 i, out_valid, in_ready, quotient, ovf, dbz);
      end
    end
    out_ready = 1'b1;
    dividend  = 43'd84;
    divisor   = 21'd4;
    in_valid  = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    out_ready = 1'b0;
    vecs++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errs++;
      $display("FAIL bp_after_handshake: got rdy=%b vld=%b, required 1 0", in_ready, out_valid);
    end
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL bp_accept: in_ready got %b, required 0", in_ready);
    end
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    vecs++;
    if (!out_valid || quotient !== 23'd21 || n != 24) begin
      errs++;
      $display("FAIL bp_second_op: got vld=%b q=%0d lat=%0d, required 1 21 24",
               out_valid, quotient, n);
    end
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    dividend = 43'd1000;
    divisor  = 21'd7;
    in_valid = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    repeat (9) @(negedge ap_clk);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    vecs++;
    if ({in_ready, out_valid, quotient, ovf, dbz} !== {1'b1, 1'b0, 23'd0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL mid_reset: got rdy=%b vld=%b q=%0d ovf=%b dbz=%b, required 1 0 0 0 0",
               in_ready, out_valid, quotient, ovf, dbz);
    end
    check_op("after_reset_9_3", 43'd9, 21'd3);
  endtask

  initial begin
    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    @(negedge ap_clk);
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/process_data_udiv_43ns_21ns_23_seq.md
Name: process_data_udiv_43ns_21ns_23_seq

Overview:
Sequential unsigned radix-2 restoring divider, the inverse of the 21x23->43 unsigned product path in process_data. Accepts a 43-bit dividend and a 21-bit divisor, and returns a 23-bit quotient plus overflow and divide-by-zero flags. Valid/ready handshakes on both sides, one operation in flight. Used to recover scaled samples after the multiply stage.

Parameters:
DIVIDEND_WIDTH, 43, dividend width; must equal QUOTIENT_WIDTH + DIVISOR_WIDTH - 1
DIVISOR_WIDTH, 21, divisor width
QUOTIENT_WIDTH, 23, quotient width; also the iteration count

Ports:
ap_clk  in  1  clock, rising edge
ap_rst  in  1  synchronous active-high reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
dividend  in  DIVIDEND_WIDTH  unsigned dividend
divisor  in  DIVISOR_WIDTH  unsigned divisor
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
quotient  out  QUOTIENT_WIDTH  unsigned quotient
ovf  out  1  true quotient exceeds 2^QUOTIENT_WIDTH-1
dbz  out  1  divisor was zero

Behaviour:
- Interface: one clock, ap_clk; reset ap_rst is synchronous and active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0, quotient=0, ovf=0, dbz=0, all internal registers 0. Reset wins over every other event, including mid-CALC and DONE; any in-flight result is discarded.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, operands are captured and the block evaluates:
  - divisor==0 -> DONE with quotient=all ones, dbz=1, ovf=0.
  - else if dividend[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH] >= divisor -> DONE with quotient=all ones, ovf=1, dbz=0. This is the saturate case.
  - else -> CALC. Partial remainder = upper DIVIDEND_WIDTH-QUOTIENT_WIDTH bits of the dividend, zero-extended to DIVISOR_WIDTH+1. Counter = QUOTIENT_WIDTH-1.
- CALC: in_ready=0. Each cycle:
  - shift {rem, next dividend bit MSB-first} left by one;
  - if result >= divisor, subtract divisor and shift in quotient bit 1; else shift in 0.
  - After QUOTIENT_WIDTH iterations -> DONE, with ovf=0 and dbz=0.
- DONE: out_valid=1; quotient, ovf, dbz and rem held stable until out_valid&&out_ready, then -> IDLE.
- in_ready is 0 in CALC and DONE. No accept in the same cycle as output handshake; back-to-back throughput is one operation per QUOTIENT_WIDTH+2 cycles.
- Latency, counted from the accepting edge to the first cycle out_valid=1:
  - normal divide: QUOTIENT_WIDTH+1 = 24 cycles;
  - dbz or ovf: 1 cycle.
- Widths: comparator and subtractor are DIVISOR_WIDTH+1 bits. Final remainder < divisor, so it fits in DIVISOR_WIDTH bits.
- Flags ovf and dbz are mutually exclusive and reflect the current result only.
- in_valid while in_ready=0 is ignored; the source holds operands per the valid/ready rule.

Optional Feature:
PROCESS_DATA_UDIV_REM_EN
- Defined: extra output port remainder, out, DIVISOR_WIDTH bits.
  - Normal divide: true remainder, valid with out_valid.
  - ovf: remainder=0.
  - dbz: remainder=dividend[DIVISOR_WIDTH-1:0].
  - Reset value 0.
- Undefined: port absent, and the final remainder register is not retained beyond CALC.

Test Plan:
- dividend=1000, divisor=7 -> quotient=142, ovf=0, dbz=0, out_valid exactly 24 cycles after accept; with REM_EN, remainder=6.
- dividend=41943039 (5*2^23-1), divisor=5 -> quotient=0x7FFFFF, ovf=0 (largest fitting result); with REM_EN, remainder=4.
- dividend=2^42, divisor=1 -> quotient=0x7FFFFF, ovf=1, out_valid 1 cycle after accept; dividend=41943040, divisor=5 -> ovf=1.
- divisor=0, dividend=12345 -> quotient=0x7FFFFF, dbz=1, ovf=0; with REM_EN, remainder=12345.
- Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout. Then release and immediately present 84/4 -> accepted the cycle after the output handshake, quotient=21.
- Assert ap_rst for 1 cycle at iteration 10 of CALC -> next cycle IDLE, in_ready=1, out_valid=0, quotient=0. A following 9/3 yields quotient=3.
